mtm_alu_deserializer: RTL and testbench

Input stage of mtm_alu. It samples the serial line sin, decodes 11-bit frames into data and command bytes, and assembles complete packets. A complete packet is 8 data bytes followed by 1 command byte; the block presents it as operands A, B and the CTL byte with a one-cycle valid pulse. Malformed traffic is discarded and reported as a one-cycle error pulse with a code. The block feeds the ALU core.

---
 rtl/mtm_alu_deserializer_if.sv | 21 ++
 rtl/mtm_alu_deserializer.sv | 129 ++++++++++++
 tb/tb_mtm_alu_deserializer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mtm_alu_deserializer_if.sv
// Serial input and decoded-packet outputs of the mtm_alu deserializer.
// slave: the deserializer itself. master: whatever drives sin and consumes packets.
interface mtm_alu_deserializer_if;
  logic        sin;
  logic [31:0] A;
  logic [31:0] B;
  logic [7:0]  ctl;
  logic        pkt_valid;
  logic        err_valid;
  logic [1:0]  err_code;

  modport master (
    output sin,
    input  A, B, ctl, pkt_valid, err_valid, err_code
  );

  modport slave (
    input  sin,
    output A, B, ctl, pkt_valid, err_valid, err_code
  );
endinterface

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu input stage: decodes 11-bit serial frames (start, type, d7..d0, stop),
// collects NUM_DATA data bytes plus one command byte into a packet and reports
// malformed traffic as a one-cycle error pulse with a held error code.
module mtm_alu_deserializer #(
  parameter int unsigned NUM_DATA = 8,
  parameter int unsigned TIMEOUT  = 32
) (
  input logic                  clk,
  input logic                  reset_n,
  mtm_alu_deserializer_if.slave bus
);

  localparam int unsigned CntW = $clog2(NUM_DATA + 2);
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(NUM_DATA);
  // Saturating marker for "more data bytes than a packet holds".
  localparam logic [CntW-1:0] CntOver = CntW'(NUM_DATA + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  localparam logic [1:0] ErrCount   = 2'b01;
  localparam logic [1:0] ErrFrame   = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  typedef enum logic [1:0] {StIdle, StPayload, StStop, StWaitIdle} state_e;

  state_e          state_q;
  logic [3:0]      bit_cnt_q;
  logic [CntW-1:0] byte_cnt_q;
  logic [TmrW-1:0] timer_q;
  logic [8:0]      frame_q;   // {type, d7..d0}
  logic [63:0]     sr_q;      // data bytes, oldest in the top byte
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic [7:0]      ctl_q;
  logic            pkt_valid_q;
  logic            err_valid_q;
  logic [1:0]      err_code_q;

  // Frame decoder, packet assembler and inter-frame timeout, all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      timer_q     <= '0;
      frame_q     <= '0;
      sr_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ctl_q       <= '0;
      pkt_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      pkt_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!bus.sin) begin
            state_q   <= StPayload;
            bit_cnt_q <= '0;
            timer_q   <= '0;
          end else if (byte_cnt_q != '0) begin
            // Partial packet waiting: give up after TIMEOUT idle clocks.
            if (timer_q == TmrLast) begin
              err_valid_q <= 1'b1;
              err_code_q  <= ErrTimeout;
              byte_cnt_q  <= '0;
              timer_q     <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end else begin
            timer_q <= '0;
          end
        end
        StPayload: begin
          frame_q   <= {frame_q[7:0], bus.sin};
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) begin
            state_q <= StStop;
          end
        end
        StStop: begin
          if (bus.sin) begin
            state_q <= StIdle;
            if (frame_q[8]) begin
              // Command byte terminates the packet whatever the data count.
              if (byte_cnt_q == CntFull) begin
                {b_q, a_q}  <= sr_q;
                ctl_q       <= frame_q[7:0];
                pkt_valid_q <= 1'b1;
              end else begin
                err_valid_q <= 1'b1;
                err_code_q  <= ErrCount;
              end
              byte_cnt_q <= '0;
            end else if (byte_cnt_q < CntFull) begin
              sr_q       <= {sr_q[55:0], frame_q[7:0]};
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end else begin
              byte_cnt_q <= CntOver;
            end
          end else begin
            state_q     <= StWaitIdle;
            err_valid_q <= 1'b1;
            err_code_q  <= ErrFrame;
            byte_cnt_q  <= '0;
          end
        end
        StWaitIdle: begin
          // A zero here is not a start bit; resync only once the line returns high.
          if (bus.sin) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.ctl       = ctl_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Bench for mtm_alu_deserializer: directed scenarios plus random packets, checked
// every clock against a frame-level model holding the received data bytes in a queue.
module tb_mtm_alu_deserializer;
  localparam int unsigned NumData = 8;
  localparam int unsigned Timeout = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mtm_alu_deserializer_if bus();

  mtm_alu_deserializer #(
    .NUM_DATA(NumData),
    .TIMEOUT (Timeout)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fails = 0;

  // Model state
  logic [7:0]  dq[$];
  int          idle_cnt = 0;
  logic [31:0] exp_a = '0;
  logic [31:0] exp_b = '0;
  logic [7:0]  exp_ctl = '0;
  logic [1:0]  exp_code = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One serial bit; ev: 0 no pulse, 1 pkt_valid, 2 err_valid expected on this sample.
  task automatic step(input logic b, input int ev);
    @(negedge clk);
    bus.sin = b;
    @(posedge clk);
    #1;
    check("pkt_valid", {63'd0, bus.pkt_valid}, {63'd0, ev == 1});
    check("err_valid", {63'd0, bus.err_valid}, {63'd0, ev == 2});
    check("A", {32'd0, bus.A}, {32'd0, exp_a});
    check("B", {32'd0, bus.B}, {32'd0, exp_b});
    check("ctl", {56'd0, bus.ctl}, {56'd0, exp_ctl});
    check("err_code", {62'd0, bus.err_code}, {62'd0, exp_code});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      int ev;
      ev = 0;
      idle_cnt++;
      if (dq.size() != 0 && idle_cnt == Timeout) begin
        dq.delete();
        idle_cnt = 0;
        exp_code = 2'b11;
        ev = 2;
      end
      step(1'b1, ev);
    end
  endtask

  task automatic hold0(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic send_frame(input logic is_cmd, input logic [7:0] data, input logic stop);
    int ev;
    idle_cnt = 0;
    step(1'b0, 0);
    step(is_cmd, 0);
    for (int i = 7; i >= 0; i--) step(data[i], 0);
    ev = 0;
    if (!stop) begin
      dq.delete();
      exp_code = 2'b10;
      ev = 2;
    end else if (is_cmd) begin
      if (dq.size() == NumData) begin
        exp_b   = {dq[0], dq[1], dq[2], dq[3]};
        exp_a   = {dq[4], dq[5], dq[6], dq[7]};
        exp_ctl = data;
        ev = 1;
      end else begin
        exp_code = 2'b01;
        ev = 2;
      end
      dq.delete();
    end else begin
      dq.push_back(data);
    end
    step(stop, ev);
  endtask

  task automatic send_packet(input logic [63:0] d, input logic [7:0] cmd, input int gap);
    for (int i = 0; i < 8; i++) begin
      send_frame(1'b0, d[63-8*i -: 8], 1'b1);
      idle(gap);
    end
    send_frame(1'b1, cmd, 1'b1);
    idle(gap);
  endtask

  task automatic send_data(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send_frame(1'b0, 8'($urandom), 1'b1);
      idle(gap);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " A"}, {32'd0, bus.A}, 64'd0);
    check({tag, " B"}, {32'd0, bus.B}, 64'd0);
    check({tag, " ctl"}, {56'd0, bus.ctl}, 64'd0);
    check({tag, " pkt_valid"}, {63'd0, bus.pkt_valid}, 64'd0);
    check({tag, " err_valid"}, {63'd0, bus.err_valid}, 64'd0);
    check({tag, " err_code"}, {62'd0, bus.err_code}, 64'd0);
  endtask

  task automatic model_reset();
    dq.delete();
    idle_cnt = 0;
    exp_a    = '0;
    exp_b    = '0;
    exp_ctl  = '0;
    exp_code = '0;
  endtask

  function automatic int rand_gap();
    if ($urandom_range(0, 9) == 0) return $urandom_range(28, 36);
    return $urandom_range(0, 2);
  endfunction

  initial begin
    // Reset state
    bus.sin = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Nominal packet, back-to-back frames
    send_packet(64'h00000002_00000001, 8'h80, 0);
    idle(3);

    // Byte order
    send_packet(64'h11223344_55667788, 8'h20, 1);

    // Short packet, long packet, then a good one
    send_data(7, 0);
    send_frame(1'b1, 8'h40, 1'b1);
    idle(2);
    send_data(9, 1);
    send_frame(1'b1, 8'h41, 1'b1);
    idle(2);
    send_packet(64'hdeadbeef_01234567, 8'h55, 0);

    // Frame error on the 3rd data frame, line held low, then recovery
    send_data(2, 0);
    send_frame(1'b0, 8'h33, 1'b0);
    hold0(5);
    idle(2);
    send_packet(64'ha5a5a5a5_5a5a5a5a, 8'h81, 0);

    // Timeout after 3 data bytes, reported once
    send_data(3, 0);
    idle(Timeout);
    idle(40);
    send_packet(64'h0badf00d_cafebabe, 8'h02, 0);

    // Gap of TIMEOUT-1 between frames must not time out
    send_data(4, Timeout - 1);
    send_data(4, 0);
    send_frame(1'b1, 8'h03, 1'b1);
    idle(1);

    // Asynchronous reset in the middle of the 4th data frame
    send_data(3, 0);
    step(1'b0, 0);
    step(1'b0, 0);
    step(1'b1, 0);
    step(1'b0, 0);
    step(1'b1, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.sin = 1'b1;
    reset_n = 1'b1;
    idle(2);
    send_packet(64'h76543210_fedcba98, 8'hc3, 0);

    // Random traffic
    for (int p = 0; p < 30; p++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : 8;
      for (int k = 0; k < n; k++) begin
        logic stop_ok;
        stop_ok = ($urandom_range(0, 29) != 0);
        send_frame(1'b0, 8'($urandom), stop_ok);
        if (!stop_ok) begin
          hold0($urandom_range(0, 3));
          idle(1 + $urandom_range(0, 2));
        end else begin
          idle(rand_gap());
        end
      end
      send_frame(1'b1, 8'($urandom), 1'b1);
      idle($urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
